// File: rtl/fx_pkg.sv
// ---------------------------------------------------------------------------
// fx_pkg
// Shared definitions for the pedalboard effect chain.
//   FX_DATA_W      codec-aligned sample width
//   FX_ACC_W       width of the wide accumulator handed to sat_to_w
//   FX_* states    2-bit bypass/fade state encodings
//   sat_to_w()     clamp a wide signed value to a w-bit signed range
// ---------------------------------------------------------------------------
package fx_pkg;

   localparam int FX_DATA_W = 32;
   localparam int FX_ACC_W  = 64;

   localparam logic [1:0] FX_BYPASS   = 2'd0;
   localparam logic [1:0] FX_FADE_IN  = 2'd1;
   localparam logic [1:0] FX_ACTIVE   = 2'd2;
   localparam logic [1:0] FX_FADE_OUT = 2'd3;

   // Result is returned full width; the caller keeps the low w bits.
   function automatic logic signed [FX_ACC_W-1:0] sat_to_w(
      input logic signed [FX_ACC_W-1:0] x,
      input int unsigned                w
   );
      logic signed [FX_ACC_W-1:0] hi;
      logic signed [FX_ACC_W-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi)
         sat_to_w = hi;
      else if (x < lo)
         sat_to_w = lo;
      else
         sat_to_w = x;
   endfunction

endpackage

// File: rtl/fx_xfade_mix.sv
// ---------------------------------------------------------------------------
// fx_xfade_mix
// One-channel registered linear crossfade:
//   out = sat((dry*(N-g) + wet*g) >>> RAMP_SHIFT), N = 2^RAMP_SHIFT
// Ports:
//   sample_clk  in   sample clock
//   resetn      in   asynchronous active-low reset (clears the output)
//   dry_i       in   dry sample (signed)
//   wet_i       in   wet sample (signed)
//   g_i         in   wet gain 0..N (unsigned)
//   out_o       out  mixed sample, registered
// ---------------------------------------------------------------------------
module fx_xfade_mix
   import fx_pkg::*;
#(
   parameter int DATA_W     = FX_DATA_W,
   parameter int RAMP_SHIFT = 8
) (
   input  logic                     sample_clk,
   input  logic                     resetn,
   input  logic signed [DATA_W-1:0] dry_i,
   input  logic signed [DATA_W-1:0] wet_i,
   input  logic [RAMP_SHIFT:0]      g_i,
   output logic signed [DATA_W-1:0] out_o
);

   localparam int PW = DATA_W + RAMP_SHIFT + 1;
   localparam int SW = PW + 1;
   localparam logic [RAMP_SHIFT:0] G_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};

   logic [RAMP_SHIFT:0]      ng;
   logic signed [PW-1:0]     dry_x;
   logic signed [PW-1:0]     wet_x;
   logic signed [PW-1:0]     g_x;
   logic signed [PW-1:0]     ng_x;
   logic signed [PW-1:0]     prod_dry;
   logic signed [PW-1:0]     prod_wet;
   logic signed [SW-1:0]     sum;
   logic signed [SW-1:0]     shifted;
   logic signed [DATA_W-1:0] mix_d;
   logic signed [DATA_W-1:0] mix_q;

   assign ng    = G_FULL - g_i;
   assign dry_x = PW'(dry_i);
   assign wet_x = PW'(wet_i);
   // Gains are unsigned: zero-extend before treating them as signed operands.
   assign g_x   = $signed(PW'(g_i));
   assign ng_x  = $signed(PW'(ng));

   // |sample| * N always fits in PW signed bits, so no product bits are lost.
   assign prod_dry = dry_x * ng_x;
   assign prod_wet = wet_x * g_x;
   assign sum      = SW'(prod_dry) + SW'(prod_wet);
   // Arithmetic shift floors; at g=0 or g=N the low bits are zero, so the
   // endpoints come out bit-exact.
   assign shifted  = sum >>> RAMP_SHIFT;
   assign mix_d    = DATA_W'(sat_to_w(FX_ACC_W'(shifted), unsigned'(DATA_W)));

   // ---- output register ----
   always_ff @(posedge sample_clk or negedge resetn) begin
      if (!resetn)
         mix_q <= '0;
      else
         mix_q <= mix_d;
   end

   assign out_o = mix_q;

endmodule

// File: rtl/fx_bypass_xfade.sv
// ---------------------------------------------------------------------------
// fx_bypass_xfade
// Click-free bypass after an effect: ramps linearly between the dry and wet
// stereo signals over 2^RAMP_SHIFT samples whenever the enable switch flips.
// Ports:
//   sample_clk            in   sample clock, all state on posedge
//   resetn                in   asynchronous active-low reset
//   enable                in   effect switch (1 = wet)
//   dry_l_in / dry_r_in   in   dry stereo samples
//   wet_l_in / wet_r_in   in   effect stereo samples
//   left_out / right_out  out  mixed stereo samples, 1 sample latency
//   active                out  state is not BYPASS
//   fading                out  state is FADE_IN or FADE_OUT
// ---------------------------------------------------------------------------
module fx_bypass_xfade
   import fx_pkg::*;
#(
   parameter int DATA_W     = FX_DATA_W,
   parameter int RAMP_SHIFT = 8
) (
   input  logic                     sample_clk,
   input  logic                     resetn,
   input  logic                     enable,
   input  logic signed [DATA_W-1:0] dry_l_in,
   input  logic signed [DATA_W-1:0] dry_r_in,
   input  logic signed [DATA_W-1:0] wet_l_in,
   input  logic signed [DATA_W-1:0] wet_r_in,
   output logic signed [DATA_W-1:0] left_out,
   output logic signed [DATA_W-1:0] right_out,
   output logic                     active,
   output logic                     fading
);

   localparam logic [RAMP_SHIFT:0] G_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};
   localparam logic [RAMP_SHIFT:0] G_ONE  = {{RAMP_SHIFT{1'b0}}, 1'b1};

   logic [1:0]          state_q, state_d;
   logic [RAMP_SHIFT:0] g_q, g_d;
   logic                active_q;
   logic                fading_q;

   // A reversal holds g for one sample and then ramps back from where it
   // was, so the output never jumps regardless of how fast enable toggles.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      case (state_q)
         FX_BYPASS: begin
            if (enable)
               state_d = FX_FADE_IN;
         end
         FX_FADE_IN: begin
            if (!enable) begin
               state_d = FX_FADE_OUT;
            end else if (g_q >= G_FULL - G_ONE) begin
               state_d = FX_ACTIVE;
               g_d     = G_FULL;
            end else begin
               g_d = g_q + G_ONE;
            end
         end
         FX_ACTIVE: begin
            if (!enable)
               state_d = FX_FADE_OUT;
         end
         FX_FADE_OUT: begin
            if (enable) begin
               state_d = FX_FADE_IN;
            end else if (g_q <= G_ONE) begin
               state_d = FX_BYPASS;
               g_d     = '0;
            end else begin
               g_d = g_q - G_ONE;
            end
         end
         default: begin
            state_d = FX_BYPASS;
            g_d     = '0;
         end
      endcase
   end

   // ---- control registers ----
   // Status flags come from the next state so they line up with the g that
   // the next mix will use.
   always_ff @(posedge sample_clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= FX_BYPASS;
         g_q      <= '0;
         active_q <= 1'b0;
         fading_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         g_q      <= g_d;
         active_q <= (state_d != FX_BYPASS);
         fading_q <= (state_d == FX_FADE_IN) || (state_d == FX_FADE_OUT);
      end
   end

   // L and R share g, so both channels ramp in lock-step.
   fx_xfade_mix #(
      .DATA_W     (DATA_W),
      .RAMP_SHIFT (RAMP_SHIFT)
   ) u_mix_l (
      .sample_clk (sample_clk),
      .resetn     (resetn),
      .dry_i      (dry_l_in),
      .wet_i      (wet_l_in),
      .g_i        (g_q),
      .out_o      (left_out)
   );

   fx_xfade_mix #(
      .DATA_W     (DATA_W),
      .RAMP_SHIFT (RAMP_SHIFT)
   ) u_mix_r (
      .sample_clk (sample_clk),
      .resetn     (resetn),
      .dry_i      (dry_r_in),
      .wet_i      (wet_r_in),
      .g_i        (g_q),
      .out_o      (right_out)
   );

   assign active = active_q;
   assign fading = fading_q;

endmodule

// File: tb/tb_fx_bypass_xfade.sv
module tb_fx_bypass_xfade;

   localparam int DW = 32;
   localparam int RS = 2;
   localparam int N  = 4;

   logic                 sample_clk = 1'b0;
   logic                 resetn     = 1'b0;
   logic                 enable     = 1'b0;
   logic signed [DW-1:0] dry_l_in   = '0;
   logic signed [DW-1:0] dry_r_in   = '0;
   logic signed [DW-1:0] wet_l_in   = '0;
   logic signed [DW-1:0] wet_r_in   = '0;
   logic signed [DW-1:0] left_out;
   logic signed [DW-1:0] right_out;
   logic                 active;
   logic                 fading;

   int total = 0;
   int bad   = 0;

   // Reference model: g steps one toward the target (N when enabled, 0 when
   // not) on every sample whose enable equals the previous sample's enable;
   // a sample where enable differs from the previous one leaves g alone.
   // Bypass means g==0 with enable low for the last two samples; fully wet
   // means g==N with enable high for the last two samples.
   int                   mg;
   bit                   men1, men2;
   logic signed [DW-1:0] exp_l, exp_r;
   logic                 exp_act, exp_fad;

   always #5 sample_clk = ~sample_clk;

   fx_bypass_xfade #(
      .DATA_W     (DW),
      .RAMP_SHIFT (RS)
   ) dut (
      .sample_clk (sample_clk),
      .resetn     (resetn),
      .enable     (enable),
      .dry_l_in   (dry_l_in),
      .dry_r_in   (dry_r_in),
      .wet_l_in   (wet_l_in),
      .wet_r_in   (wet_r_in),
      .left_out   (left_out),
      .right_out  (right_out),
      .active     (active),
      .fading     (fading)
   );

   function automatic logic signed [DW-1:0] ref_mix(input longint d, input longint w, input int g);
      longint x, q;
      x = d * (N - g) + w * g;
      q = x / N;
      if ((x % N) != 0 && x < 0) q = q - 1;
      if (q > 64'sd2147483647) q = 64'sd2147483647;
      if (q < -64'sd2147483648) q = -64'sd2147483648;
      return DW'(q);
   endfunction

   task automatic model_reset();
      mg   = 0;
      men1 = 1'b0;
      men2 = 1'b0;
   endtask

   // Predict the outputs of the coming edge from present inputs, then clock.
   task automatic tick();
      exp_l = ref_mix(dry_l_in, wet_l_in, mg);
      exp_r = ref_mix(dry_r_in, wet_r_in, mg);
      if (enable == men1) begin
         if (enable && mg < N) mg++;
         else if (!enable && mg > 0) mg--;
      end
      men2    = men1;
      men1    = enable;
      exp_act = !(mg == 0 && !men1 && !men2);
      exp_fad = exp_act && !(mg == N && men1 && men2);
      @(posedge sample_clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      @(posedge sample_clk);
      #1;
      model_reset();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      dry_l_in = 123; dry_r_in = -77; wet_l_in = 5555; wet_r_in = -9;
      enable = 1'b1;
      resetn = 1'b0;
      repeat (3) @(posedge sample_clk);
      #1;
      total++; if (left_out !== 0)  begin bad++; $display("FAIL reset_left: got %0d want 0", left_out); end
      total++; if (right_out !== 0) begin bad++; $display("FAIL reset_right: got %0d want 0", right_out); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active); end
      total++; if (fading !== 1'b0) begin bad++; $display("FAIL reset_fading: got %b want 0", fading); end
      model_reset();
      resetn = 1'b1;
      tick();
      total++; if (left_out !== 123)  begin bad++; $display("FAIL release_left: got %0d want 123", left_out); end
      total++; if (right_out !== -77) begin bad++; $display("FAIL release_right: got %0d want -77", right_out); end
      total++; if (active !== exp_act) begin bad++; $display("FAIL release_active: got %b want %b", active, exp_act); end
   endtask

   task automatic test_fade_in();
      int tab[8];
      tab = '{1000, 1000, 500, 0, -500, -1000, -1000, -1000};
      enable = 1'b0;
      do_reset();
      dry_l_in = 1000; dry_r_in = 1000; wet_l_in = -1000; wet_r_in = -1000;
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++; if (left_out !== tab[i])  begin bad++; $display("FAIL fade_in_left[%0d]: got %0d want %0d", i, left_out, tab[i]); end
         total++; if (right_out !== tab[i]) begin bad++; $display("FAIL fade_in_right[%0d]: got %0d want %0d", i, right_out, tab[i]); end
         total++; if (active !== exp_act) begin bad++; $display("FAIL fade_in_active[%0d]: got %b want %b", i, active, exp_act); end
         total++; if (fading !== exp_fad) begin bad++; $display("FAIL fade_in_fading[%0d]: got %b want %b", i, fading, exp_fad); end
      end
      total++; if (active !== 1'b1) begin bad++; $display("FAIL fade_in_end_active: got %b want 1", active); end
      total++; if (fading !== 1'b0) begin bad++; $display("FAIL fade_in_end_fading: got %b want 0", fading); end
   endtask

   task automatic test_reversal();
      int tab[4];
      tab = '{0, 0, 500, 1000};
      enable = 1'b0;
      do_reset();
      dry_l_in = 1000; dry_r_in = 1000; wet_l_in = -1000; wet_r_in = -1000;
      enable = 1'b1;
      repeat (3) begin
         tick();
         total++; if (left_out !== exp_l) begin bad++; $display("FAIL rev_ramp_left: got %0d want %0d", left_out, exp_l); end
      end
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (left_out !== tab[i])  begin bad++; $display("FAIL rev_left[%0d]: got %0d want %0d", i, left_out, tab[i]); end
         total++; if (right_out !== tab[i]) begin bad++; $display("FAIL rev_right[%0d]: got %0d want %0d", i, right_out, tab[i]); end
         total++; if (fading !== exp_fad)   begin bad++; $display("FAIL rev_fading[%0d]: got %b want %b", i, fading, exp_fad); end
      end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL rev_end_active: got %b want 0", active); end
      total++; if (fading !== 1'b0) begin bad++; $display("FAIL rev_end_fading: got %b want 0", fading); end
   endtask

   task automatic test_extremes();
      enable = 1'b0;
      do_reset();
      dry_l_in = 0; dry_r_in = 0; wet_l_in = 0; wet_r_in = 0;
      enable = 1'b1;
      repeat (3) tick();
      dry_l_in = -1; dry_r_in = -1; wet_l_in = 0; wet_r_in = 0;
      tick();
      total++; if (left_out !== -1)  begin bad++; $display("FAIL floor_left: got %0d want -1", left_out); end
      total++; if (right_out !== -1) begin bad++; $display("FAIL floor_right: got %0d want -1", right_out); end
      dry_l_in = 32'h7FFFFFFF; dry_r_in = 32'h7FFFFFFF;
      wet_l_in = 32'h7FFFFFFF; wet_r_in = 32'h7FFFFFFF;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) enable = 1'b0;
         tick();
         total++; if (left_out !== 32'sh7FFFFFFF)  begin bad++; $display("FAIL max_left[%0d]: got %0h want 7fffffff", i, left_out); end
         total++; if (right_out !== 32'sh7FFFFFFF) begin bad++; $display("FAIL max_right[%0d]: got %0h want 7fffffff", i, right_out); end
      end
      dry_l_in = 32'h80000000; wet_l_in = 32'h7FFFFFFF;
      enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         total++; if (left_out !== exp_l) begin bad++; $display("FAIL span_left[%0d]: got %0d want %0d", i, left_out, exp_l); end
      end
   endtask

   task automatic test_toggle();
      logic signed [DW-1:0] prev;
      longint step;
      enable = 1'b0;
      do_reset();
      dry_l_in = 1000; dry_r_in = 1000; wet_l_in = -1000; wet_r_in = -1000;
      prev = 0;
      for (int i = 0; i < 20; i++) begin
         enable = (i % 2 == 0);
         tick();
         total++; if (left_out !== exp_l) begin bad++; $display("FAIL toggle_left[%0d]: got %0d want %0d", i, left_out, exp_l); end
         total++; if (left_out < 500) begin bad++; $display("FAIL toggle_range[%0d]: got %0d want >=500", i, left_out); end
         step = longint'(left_out) - longint'(prev);
         if (step < 0) step = -step;
         if (i > 0) begin
            total++; if (step > 500) begin bad++; $display("FAIL toggle_step[%0d]: got %0d want <=500", i, step); end
         end
         total++; if (active !== exp_act) begin bad++; $display("FAIL toggle_active[%0d]: got %b want %b", i, active, exp_act); end
         prev = left_out;
      end
   endtask

   task automatic test_async_reset();
      enable = 1'b0;
      do_reset();
      dry_l_in = 1000; dry_r_in = 1000; wet_l_in = -1000; wet_r_in = -1000;
      enable = 1'b1;
      repeat (4) tick();
      total++; if (left_out !== exp_l) begin bad++; $display("FAIL prefade_left: got %0d want %0d", left_out, exp_l); end
      #3;
      resetn = 1'b0;
      #1;
      total++; if (left_out !== 0)  begin bad++; $display("FAIL async_left: got %0d want 0", left_out); end
      total++; if (right_out !== 0) begin bad++; $display("FAIL async_right: got %0d want 0", right_out); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL async_active: got %b want 0", active); end
      total++; if (fading !== 1'b0) begin bad++; $display("FAIL async_fading: got %b want 0", fading); end
      @(posedge sample_clk);
      #1;
      model_reset();
      resetn = 1'b1;
      enable = 1'b0;
      dry_l_in = 321; dry_r_in = -321;
      tick();
      total++; if (left_out !== 321)  begin bad++; $display("FAIL post_async_left: got %0d want 321", left_out); end
      total++; if (right_out !== -321) begin bad++; $display("FAIL post_async_right: got %0d want -321", right_out); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL post_async_active: got %b want 0", active); end
   endtask

   task automatic test_random();
      enable = 1'b0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) enable = ~enable;
         dry_l_in = $urandom; dry_r_in = $urandom;
         wet_l_in = $urandom; wet_r_in = $urandom;
         tick();
         total++; if (left_out !== exp_l)  begin bad++; $display("FAIL rand_left[%0d]: got %0d want %0d", i, left_out, exp_l); end
         total++; if (right_out !== exp_r) begin bad++; $display("FAIL rand_right[%0d]: got %0d want %0d", i, right_out, exp_r); end
         total++; if (active !== exp_act)  begin bad++; $display("FAIL rand_active[%0d]: got %b want %b", i, active, exp_act); end
         total++; if (fading !== exp_fad)  begin bad++; $display("FAIL rand_fading[%0d]: got %b want %b", i, fading, exp_fad); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fade_in();
      test_reversal();
      test_extremes();
      test_toggle();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
